// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Port indices double as the last_owner / rd_owner encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        SHARED = 2'd0,
        DRAIN  = 2'd1,
        OWNED  = 2'd2
    } arb_state_t;

    localparam logic P_DBG = 1'b0;
    localparam logic P_CPU = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // next count: clear first, then increment unless already all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {WIDTH{1'b0}};
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port word memory between the debug port (p0) and the CPU port (p1):
// round-robin arbitration, a lock handshake for exclusive debug ownership, 1-cycle read return.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    input  logic                  lock_req,
    output logic                  lock_ack,
    input  logic                  clr_stats,
    output logic [STAT_WIDTH-1:0] cpu_wait_cnt,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_t state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_owner_q, rd_owner_d;
    logic       lock_ack_q, lock_ack_d;
    logic       gnt0_s, gnt1_s;

    // grant decision and state transitions; no grant in the cycle SHARED sees lock_req
    always_comb begin
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        state_d = state_q;
        case (state_q)
            SHARED: begin
                if (lock_req) begin
                    state_d = DRAIN;
                end else if (p0_req && p1_req) begin
                    gnt0_s = (last_owner_q == P_CPU);
                    gnt1_s = (last_owner_q == P_DBG);
                end else begin
                    gnt0_s = p0_req;
                    gnt1_s = p1_req;
                end
            end
            DRAIN: begin
                if (!rd_pend_q) begin
                    state_d = lock_req ? OWNED : SHARED;
                end else begin
                    state_d = DRAIN;
                end
            end
            OWNED: begin
                gnt0_s = p0_req;
                if (!lock_req) begin
                    state_d = SHARED;
                end else begin
                    state_d = OWNED;
                end
            end
            default: begin
                state_d = SHARED;
            end
        endcase
    end

    // round-robin history and read-return bookkeeping; leaving OWNED hands the next tie to the CPU
    always_comb begin
        last_owner_d = last_owner_q;
        if (gnt0_s) begin
            last_owner_d = P_DBG;
        end else if (gnt1_s) begin
            last_owner_d = P_CPU;
        end else if ((state_q == OWNED) && !lock_req) begin
            last_owner_d = P_DBG;
        end else begin
            last_owner_d = last_owner_q;
        end
        rd_pend_d  = (gnt0_s && !p0_we) || (gnt1_s && !p1_we);
        rd_owner_d = rd_pend_d ? gnt1_s : rd_owner_q;
        lock_ack_d = (state_d == OWNED);
    end

    // arbiter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SHARED;
            last_owner_q <= P_CPU;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= P_DBG;
            lock_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
            lock_ack_q   <= lock_ack_d;
        end
    end

    // memory-side mux of the granted port, zero when idle
    always_comb begin
        mem_en    = gnt0_s || gnt1_s;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_WIDTH{1'b0}};
        mem_wdata = {DATA_WIDTH{1'b0}};
        if (gnt0_s) begin
            mem_we    = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (gnt1_s) begin
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end else begin
            mem_we    = 1'b0;
            mem_addr  = {ADDR_WIDTH{1'b0}};
            mem_wdata = {DATA_WIDTH{1'b0}};
        end
    end

    assign p0_gnt    = gnt0_s;
    assign p1_gnt    = gnt1_s;
    assign lock_ack  = lock_ack_q;
    assign p0_rvalid = rd_pend_q && (rd_owner_q == P_DBG);
    assign p1_rvalid = rd_pend_q && (rd_owner_q == P_CPU);
    assign p0_rdata  = p0_rvalid ? mem_rdata : {DATA_WIDTH{1'b0}};
    assign p1_rdata  = p1_rvalid ? mem_rdata : {DATA_WIDTH{1'b0}};

    sat_counter #(
        .WIDTH (STAT_WIDTH)
    ) u_cpu_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (p1_req && !gnt1_s),
        .clr_i (clr_stats),
        .cnt_o (cpu_wait_cnt)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with a behavioural 1-cycle-latency RAM.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we, lock_req, clr_stats;
    logic [9:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, lock_ack;
    logic [31:0] p0_rdata, p1_rdata;
    logic [15:0] cpu_wait_cnt;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] mem [0:1023];

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [31:0] P1W = 32'hC0DE_0001;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .p0_req       (p0_req),
        .p0_we        (p0_we),
        .p0_addr      (p0_addr),
        .p0_wdata     (p0_wdata),
        .p0_gnt       (p0_gnt),
        .p0_rvalid    (p0_rvalid),
        .p0_rdata     (p0_rdata),
        .p1_req       (p1_req),
        .p1_we        (p1_we),
        .p1_addr      (p1_addr),
        .p1_wdata     (p1_wdata),
        .p1_gnt       (p1_gnt),
        .p1_rvalid    (p1_rvalid),
        .p1_rdata     (p1_rdata),
        .lock_req     (lock_req),
        .lock_ack     (lock_ack),
        .clr_stats    (clr_stats),
        .cpu_wait_cnt (cpu_wait_cnt),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // RAM model: word 5 preloaded during reset, synchronous read
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[10'h005] <= 32'hDEAD_BEEF;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    typedef struct {
        logic        p0_req, p0_we;
        logic [9:0]  p0_addr;
        logic [31:0] p0_wdata;
        logic        p1_req, p1_we;
        logic [9:0]  p1_addr;
        logic        lock_req;
        logic [6:0]  e_flags;   // p0_gnt,p1_gnt,p0_rvalid,p1_rvalid,lock_ack,mem_en,mem_we
        logic [9:0]  e_addr;
        logic [31:0] e_wdata, e_rd0, e_rd1;
        logic [15:0] e_wait;
    } vec_t;

    vec_t vecs [24];

    function automatic logic [128:0] outs();
        return {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, lock_ack, mem_en, mem_we,
                mem_addr, mem_wdata, p0_rdata, p1_rdata, cpu_wait_cnt};
    endfunction

    task automatic chk(input string nm, input logic [128:0] act, input logic [128:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0,1'b0,10'h000,32'h0,        1'b0,1'b0,10'h000,1'b0, 7'b0000000,10'h000,32'h0,        32'h0,        32'h0,        16'd0};
        vecs[1]  = '{1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,10'h005,1'b0, 7'b0100010,10'h005,P1W,          32'h0,        32'h0,        16'd0};
        vecs[2]  = '{1'b0,1'b0,10'h000,32'h0,        1'b0,1'b0,10'h000,1'b0, 7'b0001000,10'h000,32'h0,        32'h0,        32'hDEADBEEF, 16'd0};
        vecs[3]  = '{1'b1,1'b1,10'h001,32'h11111111, 1'b1,1'b0,10'h005,1'b0, 7'b1000011,10'h001,32'h11111111, 32'h0,        32'h0,        16'd0};
        vecs[4]  = '{1'b1,1'b1,10'h001,32'h11111111, 1'b1,1'b0,10'h005,1'b0, 7'b0100010,10'h005,P1W,          32'h0,        32'h0,        16'd1};
        vecs[5]  = '{1'b1,1'b1,10'h001,32'h11111111, 1'b1,1'b0,10'h005,1'b0, 7'b1001011,10'h001,32'h11111111, 32'h0,        32'hDEADBEEF, 16'd1};
        vecs[6]  = '{1'b1,1'b1,10'h001,32'h11111111, 1'b1,1'b0,10'h005,1'b0, 7'b0100010,10'h005,P1W,          32'h0,        32'h0,        16'd2};
        vecs[7]  = '{1'b1,1'b1,10'h001,32'h11111111, 1'b1,1'b0,10'h001,1'b0, 7'b1001011,10'h001,32'h11111111, 32'h0,        32'hDEADBEEF, 16'd2};
        vecs[8]  = '{1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,10'h001,1'b0, 7'b0100010,10'h001,P1W,          32'h0,        32'h0,        16'd3};
        vecs[9]  = '{1'b0,1'b0,10'h000,32'h0,        1'b0,1'b0,10'h000,1'b0, 7'b0001000,10'h000,32'h0,        32'h0,        32'h11111111, 16'd3};
        vecs[10] = '{1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,10'h005,1'b0, 7'b0100010,10'h005,P1W,          32'h0,        32'h0,        16'd3};
        vecs[11] = '{1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,10'h005,1'b1, 7'b0001000,10'h000,32'h0,        32'h0,        32'hDEADBEEF, 16'd3};
        vecs[12] = '{1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,10'h005,1'b1, 7'b0000000,10'h000,32'h0,        32'h0,        32'h0,        16'd4};
        vecs[13] = '{1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,10'h005,1'b1, 7'b0000100,10'h000,32'h0,        32'h0,        32'h0,        16'd5};
        vecs[14] = '{1'b1,1'b1,10'h000,32'h12345678, 1'b1,1'b0,10'h005,1'b1, 7'b1000111,10'h000,32'h12345678, 32'h0,        32'h0,        16'd6};
        vecs[15] = '{1'b1,1'b0,10'h000,32'h0,        1'b1,1'b0,10'h005,1'b1, 7'b1000110,10'h000,32'h0,        32'h0,        32'h0,        16'd7};
        vecs[16] = '{1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,10'h005,1'b1, 7'b0010100,10'h000,32'h0,        32'h12345678, 32'h0,        16'd8};
        vecs[17] = '{1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,10'h005,1'b0, 7'b0000100,10'h000,32'h0,        32'h0,        32'h0,        16'd9};
        vecs[18] = '{1'b1,1'b0,10'h000,32'h0,        1'b1,1'b0,10'h005,1'b0, 7'b0100010,10'h005,P1W,          32'h0,        32'h0,        16'd10};
        vecs[19] = '{1'b1,1'b0,10'h000,32'h0,        1'b0,1'b0,10'h000,1'b0, 7'b1001010,10'h000,32'h0,        32'h0,        32'hDEADBEEF, 16'd10};
        vecs[20] = '{1'b0,1'b0,10'h000,32'h0,        1'b0,1'b0,10'h000,1'b0, 7'b0010000,10'h000,32'h0,        32'h12345678, 32'h0,        16'd10};
        vecs[21] = '{1'b1,1'b1,10'h003,32'hA5A5A5A5, 1'b0,1'b0,10'h000,1'b0, 7'b1000011,10'h003,32'hA5A5A5A5, 32'h0,        32'h0,        16'd10};
        vecs[22] = '{1'b1,1'b0,10'h003,32'h0,        1'b0,1'b0,10'h000,1'b0, 7'b1000010,10'h003,32'h0,        32'h0,        32'h0,        16'd10};
        vecs[23] = '{1'b0,1'b0,10'h000,32'h0,        1'b0,1'b0,10'h000,1'b0, 7'b0010000,10'h000,32'h0,        32'hA5A5A5A5, 32'h0,        16'd10};

        rst_n = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 10'h000; p0_wdata = 32'h0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 10'h000; p1_wdata = P1W;
        lock_req = 1'b0; clr_stats = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outs(), 129'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // one vector per clock: drive after the edge, compare at the falling edge
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            p0_req = vecs[i].p0_req;   p0_we = vecs[i].p0_we;
            p0_addr = vecs[i].p0_addr; p0_wdata = vecs[i].p0_wdata;
            p1_req = vecs[i].p1_req;   p1_we = vecs[i].p1_we;
            p1_addr = vecs[i].p1_addr; lock_req = vecs[i].lock_req;
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(),
                {vecs[i].e_flags, vecs[i].e_addr, vecs[i].e_wdata,
                 vecs[i].e_rd0, vecs[i].e_rd1, vecs[i].e_wait});
        end

        // saturation: CPU held off under lock until the counter reaches 0xFFFE
        @(posedge clk);
        #1;
        p0_req = 1'b0; lock_req = 1'b1;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'h005;
        for (int g = 0; g < 70000; g++) begin
            @(negedge clk);
            if (cpu_wait_cnt == 16'hFFFE) break;
        end
        chk("sat_reach_fffe", {113'd0, cpu_wait_cnt}, {113'd0, 16'hFFFE});
        repeat (3) @(negedge clk);
        chk("sat_hold_ffff", {113'd0, cpu_wait_cnt}, {113'd0, 16'hFFFF});
        chk("owned_blocks_p1", {127'd0, lock_ack, p1_gnt}, {127'd0, 1'b1, 1'b0});
        @(posedge clk);
        #1 clr_stats = 1'b1;
        @(posedge clk);
        #1 clr_stats = 1'b0;
        @(negedge clk);
        chk("clr_beats_inc", {113'd0, cpu_wait_cnt}, 129'd0);
        @(negedge clk);
        chk("inc_after_clr", {113'd0, cpu_wait_cnt}, {113'd0, 16'd1});

        // reset in the cycle after a debug read grant discards the pending read
        @(posedge clk);
        #1 lock_req = 1'b0; p1_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h000;
        @(negedge clk);
        chk("rst_pre_gnt", {127'd0, p0_gnt, p1_gnt}, {127'd0, 2'b10});
        @(posedge clk);
        #1 rst_n = 1'b0; p0_req = 1'b0;
        #1 chk("rst_async_outputs", outs(), 129'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_quiet", outs(), 129'd0);
        @(posedge clk);
        #1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h000;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'h005;
        @(negedge clk);
        chk("rst_shared_p0_first", {127'd0, p0_gnt, p1_gnt}, {127'd0, 2'b10});
        @(posedge clk);
        #1 p0_req = 1'b0; p1_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
